// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - TX FIFO drain handshake between FIFO head and UART serializer
// Signals:
//   fifo_data          FIFO head byte, valid while fifo_data_present=1
//   fifo_data_present  FIFO not empty
//   fifo_read          one-clk pop strobe from the serializer
// master = FIFO side, slave = serializer side.
interface uart_tx_serializer_if;
    logic [7:0] fifo_data;
    logic       fifo_data_present;
    logic       fifo_read;

    modport master (
        output fifo_data,
        output fifo_data_present,
        input  fifo_read
    );

    modport slave (
        input  fifo_data,
        input  fifo_data_present,
        output fifo_read
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - pops TX FIFO bytes and shifts them out as async UART frames
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   en_16x_baud_i    one-clk pulse at OVERSAMPLE x baud
//   fifo_if          FIFO head data / present in, pop strobe out
//   parity_en_i      insert parity bit after data
//   parity_odd_i     odd (1) or even (0) parity
//   two_stop_i       two stop bits (1) or one (0)
//   tx_o             registered serial output, idle high
//   busy_o           high while a frame is in progress
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_16x_baud_i,
    uart_tx_serializer_if.slave         fifo_if,
    input  logic                        parity_en_i,
    input  logic                        parity_odd_i,
    input  logic                        two_stop_i,
    output logic                        tx_o,
    output logic                        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    state_e     state_q;
    logic [3:0] tick_cnt_q;
    logic [2:0] bit_cnt_q;
    logic       stop_cnt_q;
    logic [7:0] shift_q;
    logic       par_bit_q;
    logic       par_en_q;
    logic       two_stop_q;
    logic       tx_q;
    logic       busy_q;

    logic       bit_end;
    logic       last_stop;
    logic       pop_req;

    assign bit_end   = en_16x_baud_i && (tick_cnt_q == TICK_LAST);
    assign last_stop = (stop_cnt_q == two_stop_q);

    // Load from IDLE on any cycle, or directly at the end of the final stop bit
    // so consecutive frames have no idle gap.
    assign pop_req = fifo_if.fifo_data_present &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_STOP) && bit_end && last_stop));

    // Reset keeps the pop strobe quiet even though the FSM sits in IDLE.
    assign fifo_if.fifo_read = pop_req && rst_n;

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'h00;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else if (pop_req) begin
            // Frame configuration is frozen here; the parity bit is computed
            // now because the byte is shifted away before it is sent.
            shift_q    <= fifo_if.fifo_data;
            par_bit_q  <= (^fifo_if.fifo_data) ^ parity_odd_i;
            par_en_q   <= parity_en_i;
            two_stop_q <= two_stop_i;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            state_q    <= S_START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
        end else if ((state_q != S_IDLE) && en_16x_baud_i) begin
            tick_cnt_q <= bit_end ? 4'd0 : tick_cnt_q + 4'd1;
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= 3'd0;
                        state_q   <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_cnt_q == 3'd7) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= S_STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= S_STOP;
                    end
                    S_STOP: begin
                        if (last_stop) begin
                            // A waiting byte was taken by the load branch above.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
